// File: rtl/set_injector_pkg.sv
// Shared types for the set injector: opcode and FSM encodings plus the latched command record.
// Command fields are sized for the largest supported channel (64 bits), index (8 bits) and duration (32 bits).
package set_injector_pkg;

    typedef enum logic [1:0] {
        OP_SET   = 2'b00,
        OP_PULSE = 2'b01,
        OP_WAIT  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } state_e;

    localparam int CMD_IDX_W  = 8;
    localparam int CMD_DATA_W = 64;
    localparam int CMD_DUR_W  = 32;

    typedef struct packed {
        op_e                   op;
        logic [CMD_IDX_W-1:0]  idx;
        logic [CMD_DATA_W-1:0] data;
        logic [CMD_DUR_W-1:0]  dur;
    } cmd_t;

endpackage

// File: rtl/set_injector_tb_sync_fifo.sv
// Single-clock FIFO with full/empty flags; the head entry is readable combinationally.
// Pointers carry one extra wrap bit to tell full from empty.
module tb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_wr, do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/set_injector.sv
// Drives a bank of alias channels from a queue of SET / PULSE / WAIT commands.
// SET_WIDTH, DUR_WIDTH and the index width must fit the command record fields in the package.
module set_injector
    import set_injector_pkg::*;
#(
    parameter int                   SET_SIZE   = 5,
    parameter int                   SET_WIDTH  = 32,
    parameter int                   DUR_WIDTH  = 16,
    parameter int                   FIFO_DEPTH = 4,
    parameter logic [SET_WIDTH-1:0] SET_INIT   = '0,
    localparam int                  IDX_W      = (SET_SIZE > 1) ? $clog2(SET_SIZE) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [IDX_W-1:0]              cmd_idx,
    input  logic [SET_WIDTH-1:0]          cmd_data,
    input  logic [DUR_WIDTH-1:0]          cmd_dur,
    output logic [SET_SIZE*SET_WIDTH-1:0] set_o,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    localparam int FW = 2 + IDX_W + SET_WIDTH + DUR_WIDTH;

    state_e               state_q, state_d;
    cmd_t                 cmd_q, cmd_d;
    logic [DUR_WIDTH-1:0] cnt_q, cnt_d;
    logic [SET_WIDTH-1:0] save_q, save_d;
    logic                 done_q, done_d, err_q, err_d;

    logic                 fifo_full, fifo_empty, fifo_pop;
    logic [FW-1:0]        fifo_rd;
    logic [1:0]           f_op;
    logic [IDX_W-1:0]     f_idx;
    logic [SET_WIDTH-1:0] f_data;
    logic [DUR_WIDTH-1:0] f_dur;

    logic [IDX_W-1:0]     idx_sel;
    logic [SET_WIDTH-1:0] data_sel, cur_val, chan_wd;
    logic [DUR_WIDTH-1:0] dur_sel;
    logic                 chan_we, cmd_bad, unused_cmd_bits;

    tb_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (cmd_valid && cmd_ready),
        .wr_data ({cmd_op, cmd_idx, cmd_data, cmd_dur}),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign {f_op, f_idx, f_data, f_dur} = fifo_rd;

    assign idx_sel  = cmd_q.idx[IDX_W-1:0];
    assign data_sel = cmd_q.data[SET_WIDTH-1:0];
    assign dur_sel  = cmd_q.dur[DUR_WIDTH-1:0];
    // Field bits above the configured widths are always zero.
    assign unused_cmd_bits = ^{cmd_q.idx, cmd_q.data, cmd_q.dur};

    assign cmd_bad = (cmd_q.op == OP_RSVD)
                  || ((cmd_q.op == OP_SET || cmd_q.op == OP_PULSE) && int'(cmd_q.idx) >= SET_SIZE)
                  || ((cmd_q.op == OP_PULSE || cmd_q.op == OP_WAIT) && cmd_q.dur == '0);

    always_comb begin
        cur_val = SET_INIT;
        for (int k = 0; k < SET_SIZE; k++) begin
            if (idx_sel == IDX_W'(k)) cur_val = set_o[k*SET_WIDTH +: SET_WIDTH];
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        save_d   = save_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fifo_pop = 1'b0;
        chan_we  = 1'b0;
        chan_wd  = data_sel;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    cmd_d.op   = op_e'(f_op);
                    cmd_d.idx  = CMD_IDX_W'(f_idx);
                    cmd_d.data = CMD_DATA_W'(f_data);
                    cmd_d.dur  = CMD_DUR_W'(f_dur);
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
                if (cmd_bad) begin
                    err_d = 1'b1;
                end else begin
                    case (cmd_q.op)
                        OP_SET: begin
                            chan_we = 1'b1;
                            done_d  = 1'b1;
                        end
                        OP_PULSE: begin
                            save_d  = cur_val;
                            chan_we = 1'b1;
                            cnt_d   = dur_sel - DUR_WIDTH'(1);
                            state_d = HOLD;
                        end
                        OP_WAIT: begin
                            cnt_d   = dur_sel - DUR_WIDTH'(1);
                            state_d = HOLD;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    chan_we = (cmd_q.op == OP_PULSE);
                    chan_wd = save_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - DUR_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            save_q  <= SET_INIT;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            save_q  <= save_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    for (genvar gi = 0; gi < SET_SIZE; gi++) begin : g_chan
        logic [SET_WIDTH-1:0] ch_q, ch_d;

        always_comb begin
            ch_d = ch_q;
            if (chan_we && idx_sel == IDX_W'(gi)) ch_d = chan_wd;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) ch_q <= SET_INIT;
            else        ch_q <= ch_d;
        end

        assign set_o[gi*SET_WIDTH +: SET_WIDTH] = ch_q;
    end

    assign cmd_ready = !fifo_full;
    // The completion cycle (done/err visible) still counts as busy.
    assign busy      = !fifo_empty || (state_q != IDLE) || done_q || err_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_set_injector.sv
// Directed bench for set_injector: a vector table of single commands plus
// hand-written sequences for pulse timing, FIFO back-pressure, reset and back-to-back completion.
module tb_set_injector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [2:0]   cmd_idx;
    logic [31:0]  cmd_data;
    logic [15:0]  cmd_dur;
    logic [159:0] set_o;
    logic         busy, done, err;

    set_injector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_idx   (cmd_idx),
        .cmd_data  (cmd_data),
        .cmd_dur   (cmd_dur),
        .set_o     (set_o),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] model [5];

    typedef struct {
        logic [1:0]  op;
        logic [2:0]  idx;
        logic [31:0] data;
        logic [15:0] dur;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] pack_model();
        logic [159:0] p;
        for (int k = 0; k < 5; k++) p[k*32 +: 32] = model[k];
        return p;
    endfunction

    task automatic push(input logic [1:0] op, input logic [2:0] idx, input logic [31:0] data, input logic [15:0] dur);
        cmd_op    = op;
        cmd_idx   = idx;
        cmd_data  = data;
        cmd_dur   = dur;
        cmd_valid = 1'b1;
        chk("push_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        $display("push op=%0d idx=%0d data=%h dur=%0d", op, idx, data, dur);
    endtask

    task automatic run_vec(input vec_t v);
        int   t;
        logic got_done, got_err;
        push(v.op, v.idx, v.data, v.dur);
        t = 0;
        got_done = 1'b0;
        got_err  = 1'b0;
        while (!got_done && !got_err && t < 200) begin
            tick();
            t++;
            got_done = done;
            got_err  = err;
        end
        if (!v.exp_err && v.op == 2'b00) model[v.idx] = v.data;
        chk("vec_kind", {got_done, got_err}, {~v.exp_err, v.exp_err});
        chk("vec_latency", t, v.exp_lat);
        chk("vec_set_o", set_o, pack_model());
        $display("vec op=%0d idx=%0d done=%0b err=%0b lat=%0d set_o=%h", v.op, v.idx, got_done, got_err, t, set_o);
    endtask

    initial begin
        int done_cnt, acc_t, done_t;

        vecs[0] = '{2'b00, 3'd2, 32'hCAFEDECA, 16'd0, 1'b0, 2};
        vecs[1] = '{2'b00, 3'd1, 32'h00005678, 16'd0, 1'b0, 2};
        vecs[2] = '{2'b00, 3'd4, 32'hFFFFFFFF, 16'd0, 1'b0, 2};
        vecs[3] = '{2'b00, 3'd5, 32'h11111111, 16'd0, 1'b1, 2};
        vecs[4] = '{2'b11, 3'd0, 32'h22222222, 16'd4, 1'b1, 2};
        vecs[5] = '{2'b01, 3'd0, 32'h33333333, 16'd0, 1'b1, 2};
        vecs[6] = '{2'b10, 3'd0, 32'h0,        16'd0, 1'b1, 2};
        vecs[7] = '{2'b10, 3'd0, 32'h0,        16'd1, 1'b0, 3};
        vecs[8] = '{2'b01, 3'd3, 32'h0000AAAA, 16'd2, 1'b0, 4};
        vecs[9] = '{2'b00, 3'd0, 32'h00000001, 16'd0, 1'b0, 2};

        for (int k = 0; k < 5; k++) model[k] = 32'h0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_idx   = 3'd0;
        cmd_data  = 32'h0;
        cmd_dur   = 16'd0;

        tick();
        tick();
        chk("rst_set_o", set_o, 160'h0);
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Pulse on channel 1 over its previous value 0x5678.
        push(2'b01, 3'd1, 32'h00001234, 16'd3);
        for (int t = 1; t <= 8; t++) begin
            tick();
            chk("pulse_ch1", set_o[63:32], (t >= 2 && t <= 4) ? 32'h00001234 : 32'h00005678);
            chk("pulse_done", done, (t == 5));
            $display("pulse t=%0d ch1=%h done=%0b", t, set_o[63:32], done);
        end

        // Fill the FIFO behind a long WAIT.
        push(2'b10, 3'd0, 32'h0, 16'd100);
        tick();
        tick();
        for (int j = 0; j < 4; j++) push(2'b00, 3'(j), 32'h10 + 32'(j), 16'd0);
        chk("full_ready_low", cmd_ready, 1'b0);
        cmd_op    = 2'b00;
        cmd_idx   = 3'd4;
        cmd_data  = 32'h14;
        cmd_valid = 1'b1;
        done_cnt  = 0;
        acc_t     = -1;
        done_t    = -1;
        for (int t = 0; t < 400 && done_cnt < 6; t++) begin
            if (cmd_valid && cmd_ready) acc_t = t;
            tick();
            if (acc_t == t) cmd_valid = 1'b0;
            if (done) begin
                if (done_cnt == 0) done_t = t;
                else model[done_cnt-1] = 32'h10 + 32'(done_cnt - 1);
                chk("fifo_order_set_o", set_o, pack_model());
                $display("fifo done #%0d t=%0d set_o=%h", done_cnt, t, set_o);
                done_cnt++;
            end
        end
        cmd_valid = 1'b0;
        chk("fifo_done_count", done_cnt, 6);
        chk("fifo_accept_after_pop", acc_t - done_t, 2);

        // Reset in the middle of a pulse on channel 0.
        push(2'b01, 3'd0, 32'h0000DEAD, 16'd10);
        for (int t = 1; t <= 4; t++) tick();
        chk("midpulse_ch0", set_o[31:0], 32'h0000DEAD);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) model[k] = 32'h0;
        chk("midrst_set_o", set_o, 160'h0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_ready", cmd_ready, 1'b1);
        for (int t = 0; t < 2; t++) begin
            tick();
            chk("midrst_no_done", {done, err}, 2'b00);
        end
        rst_n = 1'b1;
        $display("reset released mid-pulse");
        run_vec('{2'b00, 3'd3, 32'h00000077, 16'd0, 1'b0, 2});

        // WAIT dur=1 followed immediately by a SET.
        push(2'b10, 3'd0, 32'h0, 16'd1);
        push(2'b00, 3'd1, 32'h00000099, 16'd0);
        for (int t = 1; t <= 7; t++) begin
            if (t > 1) tick();
            chk("b2b_done", done, (t == 3 || t == 5));
            chk("b2b_busy", busy, (t <= 5));
            $display("b2b t=%0d done=%0b busy=%0b", t, done, busy);
        end
        model[1] = 32'h00000099;
        chk("b2b_set_o", set_o, pack_model());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
